// File: rtl/status_flag_evaluator.sv
// Flag register, branch-condition evaluator and LIFO flag save stack.
// Latency: query result one cycle after accept; flag/stack state visible the cycle after the edge.
// Backpressure: one-entry result register; q_ready drops while a result is held with r_ready low.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   upd_valid, upd_*         load {sign,zero,overflow,carry,parity} into the flag register
//   q_valid/q_ready/q_cond   condition query handshake and 4-bit condition code
//   r_valid/r_ready/r_taken  result handshake and evaluated condition
//   push, pop                save/restore flag context on the stack
//   flags_out                flag register {S,Z,V,C,P}
//   stack_full/empty/err     registered stack status; err pulses one cycle per illegal op
module status_flag_evaluator #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       upd_valid,
  input  logic       upd_sign,
  input  logic       upd_zero,
  input  logic       upd_overflow,
  input  logic       upd_carry,
  input  logic       upd_parity,
  input  logic       q_valid,
  output logic       q_ready,
  input  logic [3:0] q_cond,
  output logic       r_valid,
  input  logic       r_ready,
  output logic       r_taken,
  input  logic       push,
  input  logic       pop,
  output logic [4:0] flags_out,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       stack_err
);

  localparam int              CW        = $clog2(DEPTH + 1);
  // Storage rounded up to a power of two so the count indexes it directly;
  // entries at or beyond DEPTH are never written or read as valid data.
  localparam int              SLOTS     = 1 << CW;
  localparam logic [CW-1:0]   FULL_CNT  = CW'(DEPTH);
  localparam logic [4:0]      RST_FLAGS = 5'b01001;   // flags of 0 + 0

  logic [4:0]    flags;
  logic [4:0]    flags_nxt;
  logic [4:0]    upd_vec;
  logic [4:0]    stk [SLOTS];
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] count_m1;
  logic          is_full;
  logic          is_empty;
  logic          push_ok;
  logic          pop_ok;
  logic          op_err;
  logic          accept;

  function automatic logic eval_cond(input logic [3:0] cc, input logic [4:0] f);
    logic s, z, v, c, p, res;
    {s, z, v, c, p} = f;
    res = 1'b0;
    case (cc)
      4'd0:  res = z;
      4'd1:  res = ~z;
      4'd2:  res = c;
      4'd3:  res = ~c;
      4'd4:  res = s;
      4'd5:  res = ~s;
      4'd6:  res = v;
      4'd7:  res = ~v;
      4'd8:  res = c & ~z;
      4'd9:  res = ~c | z;
      4'd10: res = (s == v);
      4'd11: res = (s != v);
      4'd12: res = ~z & (s == v);
      4'd13: res = z | (s != v);
      4'd14: res = p;
      4'd15: res = 1'b1;
    endcase
    return res;
  endfunction

  assign upd_vec  = {upd_sign, upd_zero, upd_overflow, upd_carry, upd_parity};
  assign is_full  = (count == FULL_CNT);
  assign is_empty = (count == '0);
  assign count_m1 = count - CW'(1);

  // push and pop together cancel each other and flag an error; a lone op
  // is illegal only against a full (push) or empty (pop) stack.
  assign push_ok = push & ~pop & ~is_full;
  assign pop_ok  = pop & ~push & ~is_empty;
  assign op_err  = (push & pop) | (push & ~pop & is_full) | (pop & ~push & is_empty);

  always_comb begin
    count_nxt = count;
    if (push_ok) begin
      count_nxt = count + CW'(1);
    end else if (pop_ok) begin
      count_nxt = count_m1;
    end
  end

  // A restore takes precedence over a same-cycle update; a failed pop or a
  // push leaves the update path open.
  always_comb begin
    flags_nxt = flags;
    if (pop_ok) begin
      flags_nxt = stk[count_m1];
    end else if (upd_valid) begin
      flags_nxt = upd_vec;
    end
  end

  // Result register refills whenever it is empty or being drained.
  assign q_ready = ~r_valid | r_ready;
  assign accept  = q_valid & q_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      flags       <= RST_FLAGS;
      count       <= '0;
      stack_full  <= 1'b0;
      stack_empty <= 1'b1;
      stack_err   <= 1'b0;
      r_valid     <= 1'b0;
      r_taken     <= 1'b0;
    end else begin
      flags       <= flags_nxt;
      count       <= count_nxt;
      stack_full  <= (count_nxt == FULL_CNT);
      stack_empty <= (count_nxt == '0);
      stack_err   <= op_err;
      // Evaluated against the pre-edge flags: no bypass from update or pop.
      if (accept) begin
        r_valid <= 1'b1;
        r_taken <= eval_cond(q_cond, flags);
      end else if (r_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Stack contents need no reset; count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      stk[count] <= flags;
    end
  end

  assign flags_out = flags;

endmodule
